// File: rtl/boid_update_unit.sv
// Boid position updater: steps every boid once per frame_tick, bouncing off the
// screen edges, and streams one {id, x, y, address} record per boid over a
// valid/ready handshake.
module boid_update_unit #(
  parameter int unsigned N_BOIDS      = 8,
  parameter int unsigned VIDEO_WIDTH  = 640,
  parameter int unsigned VIDEO_HEIGHT = 480,
  localparam int unsigned PIXEL_ADDRESS_WIDTH = $clog2(VIDEO_WIDTH * VIDEO_HEIGHT) + 1,
  localparam int unsigned ID_W = (N_BOIDS > 1) ? $clog2(N_BOIDS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_tick,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic [9:0]                     x_loc,
  output logic [8:0]                     y_loc,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] address,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned PAW = PIXEL_ADDRESS_WIDTH;
  localparam logic signed [11:0] XMax = 12'(VIDEO_WIDTH - 1);
  localparam logic signed [11:0] YMax = 12'(VIDEO_HEIGHT - 1);
  localparam logic [PAW-1:0] RowPitch = PAW'(VIDEO_WIDTH);
  localparam logic [ID_W-1:0] LastId = ID_W'(N_BOIDS - 1);

  typedef enum logic [1:0] {StIdle, StUpdate, StEmit} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic            overrun_q, overrun_d;

  // Per-boid state; direction stored as a "negative" flag (dx = -1 when set).
  logic [9:0] x_q      [N_BOIDS];
  logic [8:0] y_q      [N_BOIDS];
  logic       dx_neg_q [N_BOIDS];
  logic       dy_neg_q [N_BOIDS];

  logic [ID_W-1:0] out_id_q;
  logic [9:0]      x_loc_q;
  logic [8:0]      y_loc_q;
  logic [PAW-1:0]  addr_q;

  logic signed [11:0] nx, ny;
  logic [9:0]         x_new;
  logic [8:0]         y_new;
  logic               x_flip, y_flip;
  logic [PAW-1:0]     addr_new;

  // State register, boid index and registered overrun pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic; frame_tick outside IDLE is dropped and flagged.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = frame_tick && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          idx_d   = '0;
          state_d = StUpdate;
        end
      end
      StUpdate: state_d = StEmit;
      StEmit: begin
        if (out_ready) begin
          if (idx_q == LastId) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StUpdate;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state plus the registered record fields.
  always_comb begin
    out_valid = (state_q == StEmit);
    busy      = (state_q != StIdle);
    overrun   = overrun_q;
    out_id    = out_id_q;
    x_loc     = x_loc_q;
    y_loc     = y_loc_q;
    address   = addr_q;
  end

  // One-step move with edge bounce for the boid at idx_q.
  always_comb begin
    nx = $signed({2'b00, x_q[idx_q]}) + (dx_neg_q[idx_q] ? -12'sd1 : 12'sd1);
    ny = $signed({3'b000, y_q[idx_q]}) + (dy_neg_q[idx_q] ? -12'sd1 : 12'sd1);
    x_flip = 1'b0;
    y_flip = 1'b0;
    if (nx < 0) begin
      x_new  = '0;
      x_flip = 1'b1;
    end else if (nx > XMax) begin
      x_new  = XMax[9:0];
      x_flip = 1'b1;
    end else begin
      x_new = nx[9:0];
    end
    if (ny < 0) begin
      y_new  = '0;
      y_flip = 1'b1;
    end else if (ny > YMax) begin
      y_new  = YMax[8:0];
      y_flip = 1'b1;
    end else begin
      y_new = ny[8:0];
    end
    addr_new = PAW'(x_new) + RowPitch * PAW'(y_new);
  end

  // Boid storage and output record; written only in the single UPDATE cycle so
  // a stalled EMIT never re-steps the boid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BOIDS; i++) begin
        x_q[i]      <= 10'(10 + 16 * i);
        y_q[i]      <= 9'(10 + 8 * i);
        dx_neg_q[i] <= 1'(i % 2);
        dy_neg_q[i] <= 1'b0;
      end
      out_id_q <= '0;
      x_loc_q  <= '0;
      y_loc_q  <= '0;
      addr_q   <= '0;
    end else if (state_q == StUpdate) begin
      x_q[idx_q]      <= x_new;
      y_q[idx_q]      <= y_new;
      dx_neg_q[idx_q] <= dx_neg_q[idx_q] ^ x_flip;
      dy_neg_q[idx_q] <= dy_neg_q[idx_q] ^ y_flip;
      out_id_q        <= idx_q;
      x_loc_q         <= x_new;
      y_loc_q         <= y_new;
      addr_q          <= addr_new;
    end
  end

endmodule

// File: tb/tb_boid_update_unit.sv
// Directed bench for boid_update_unit at default parameters.
module tb_boid_update_unit;

  localparam int NB = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_id;
  logic [9:0]  x_loc;
  logic [8:0]  y_loc;
  logic [19:0] address;
  logic        busy;
  logic        overrun;

  boid_update_unit dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .x_loc      (x_loc),
    .y_loc      (y_loc),
    .address    (address),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #10 clock = ~clock;

  typedef struct {
    int id;
    int x;
    int y;
    int addr;
  } rec_t;

  rec_t exp_tbl [NB];
  rec_t recs    [NB];
  int   n_recs, busy_cyc, ov_cnt, first_valid;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Run one frame; optionally stall id stall_id for 5 EMIT cycles and/or pulse
  // frame_tick during cycle inject_cyc of the frame.
  task automatic run_frame(input int stall_id, input int inject_cyc);
    int   stall_left;
    bit   snap_taken;
    rec_t snap;
    n_recs      = 0;
    busy_cyc    = 0;
    ov_cnt      = 0;
    first_valid = -1;
    stall_left  = 5;
    snap_taken  = 1'b0;
    out_ready   = 1'b1;
    frame_tick  = 1'b1;
    tick_edge();
    frame_tick = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      frame_tick = (cyc == inject_cyc);
      if (overrun) ov_cnt++;
      if (!busy) break;
      busy_cyc++;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (int'(out_id) == stall_id && stall_left > 0) begin
          if (!snap_taken) begin
            snap       = '{int'(out_id), int'(x_loc), int'(y_loc), int'(address)};
            snap_taken = 1'b1;
          end else begin
            check("stall_id", int'(out_id), snap.id);
            check("stall_x", int'(x_loc), snap.x);
            check("stall_y", int'(y_loc), snap.y);
            check("stall_addr", int'(address), snap.addr);
          end
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (n_recs < NB) recs[n_recs] = '{int'(out_id), int'(x_loc), int'(y_loc),
                                           int'(address)};
          n_recs++;
        end
      end
      tick_edge();
    end
    frame_tick = 1'b0;
    out_ready  = 1'b1;
    check("frame_ends", int'(busy), 0);
  endtask

  initial begin
    exp_tbl[0] = '{0, 11, 11, 7051};
    exp_tbl[1] = '{1, 25, 19, 12185};
    exp_tbl[2] = '{2, 43, 27, 17323};
    exp_tbl[3] = '{3, 57, 35, 22457};
    exp_tbl[4] = '{4, 75, 43, 27595};
    exp_tbl[5] = '{5, 89, 51, 32729};
    exp_tbl[6] = '{6, 107, 59, 37867};
    exp_tbl[7] = '{7, 121, 67, 43001};

    reset      = 1'b0;
    frame_tick = 1'b0;
    out_ready  = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    // Asynchronous reset values, before any clock edge.
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_id", int'(out_id), 0);
    check("rst_x", int'(x_loc), 0);
    check("rst_y", int'(y_loc), 0);
    check("rst_addr", int'(address), 0);
    tick_edge();
    tick_edge();
    @(negedge clock);
    reset = 1'b0;

    // First frame after reset: latency, busy length, full record table.
    run_frame(-1, -1);
    check("f1_first_valid_cyc", first_valid, 1);
    check("f1_busy_cycles", busy_cyc, 2 * NB);
    check("f1_records", n_recs, NB);
    check("f1_overrun", ov_cnt, 0);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("f1_id[%0d]", k), recs[k].id, exp_tbl[k].id);
      check($sformatf("f1_x[%0d]", k), recs[k].x, exp_tbl[k].x);
      check($sformatf("f1_y[%0d]", k), recs[k].y, exp_tbl[k].y);
      check($sformatf("f1_addr[%0d]", k), recs[k].addr, exp_tbl[k].addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick_edge();
      check("idle_busy", int'(busy), 0);
    end

    // Stall on id0 for 5 cycles; boid 0 must step exactly once.
    do_reset();
    run_frame(0, -1);
    check("stall_busy_cycles", busy_cyc, 2 * NB + 5);
    check("stall_records", n_recs, NB);
    check("stall_rec0_id", recs[0].id, 0);
    check("stall_rec0_x", recs[0].x, 11);
    check("stall_rec0_y", recs[0].y, 11);
    check("stall_rec1_id", recs[1].id, 1);
    run_frame(-1, -1);
    check("after_stall_x0", recs[0].x, 12);
    check("after_stall_y0", recs[0].y, 12);
    check("after_stall_x1", recs[1].x, 24);

    // frame_tick while busy: one overrun pulse, frame unaffected, no extra frame.
    do_reset();
    run_frame(-1, 5);
    check("ovr_count", ov_cnt, 1);
    check("ovr_records", n_recs, NB);
    check("ovr_busy_cycles", busy_cyc, 2 * NB);
    check("ovr_last_id", recs[NB-1].id, NB - 1);
    for (int k = 0; k < 4; k++) begin
      tick_edge();
      check("ovr_no_extra_frame", int'(busy), 0);
    end

    // Reset while id3 is being emitted.
    do_reset();
    tick_edge();
    out_ready  = 1'b1;
    frame_tick = 1'b1;
    tick_edge();
    frame_tick = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int cyc = 0; cyc < 50; cyc++) begin
        if (out_valid && out_id == 3'd3) begin
          found = 1'b1;
          break;
        end
        tick_edge();
      end
      check("midreset_found_id3", int'(found), 1);
    end
    reset = 1'b1;
    #1;
    check("midreset_valid", int'(out_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_x", int'(x_loc), 0);
    check("midreset_addr", int'(address), 0);
    @(negedge clock);
    reset = 1'b0;
    run_frame(-1, -1);
    check("midreset_records", n_recs, NB);
    check("midreset_rec0_id", recs[0].id, 0);
    check("midreset_rec0_x", recs[0].x, 11);
    check("midreset_rec0_y", recs[0].y, 11);

    // Long run: boid 1 bounces off x=0, boid 0 bounces off y=479.
    do_reset();
    for (int f = 1; f <= 471; f++) begin
      run_frame(-1, -1);
      if (f == 26)  check("b1_x_f26", recs[1].x, 0);
      if (f == 27)  check("b1_x_f27", recs[1].x, 0);
      if (f == 28)  check("b1_x_f28", recs[1].x, 1);
      if (f == 469) check("b0_y_f469", recs[0].y, 479);
      if (f == 470) check("b0_y_f470", recs[0].y, 479);
      if (f == 471) begin
        check("b0_y_f471", recs[0].y, 478);
        check("b0_x_f471", recs[0].x, 481);
        check("b0_addr_f471", recs[0].addr, 481 + 640 * 478);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
